alu_seq: RTL and testbench

- Parametrised multi-cycle ALU, the next generation of the datapath arithmetic unit in the RSA encoder/decoder.
- Adds a valid/ready handshake on input and output, a WIDTH parameter, an iterative multiply and an iterative modulo for modular-exponentiation steps, and carry and error flags.
- Single-cycle ops complete one cycle after acceptance. MUL and MOD run a WIDTH-step shift loop.
- Sits between the control FSM and the register file.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_seq_iter.sv | 93 +++++++++
 rtl/alu_seq.sv | 132 +++++++++++++
 tb/tb_alu_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and shift-engine mode definitions for the sequential ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_SLT  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_MOD  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   // Shift-engine mode select
   localparam logic ITER_MUL = 1'b0;
   localparam logic ITER_MOD = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// WIDTH-step shift engine shared by MUL (shift-add, LSB first) and MOD
// (restoring division, MSB first). done/result/overflow are valid in the
// cycle before the final step edge, so the caller loads them on that edge.
module alu_seq_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic                 busy_q,   busy_d;
   logic                 mode_q,   mode_d;
   logic [CW-1:0]        cnt_q,    cnt_d;
   logic [2*WIDTH-1:0]   acc_q,    acc_d;     // product accumulator
   logic [2*WIDTH-1:0]   mcand_q,  mcand_d;   // multiplicand, shifted left per step
   logic [WIDTH-1:0]     shreg_q,  shreg_d;   // multiplier, or dividend when dividing
   logic [WIDTH:0]       rem_q,    rem_d;     // partial remainder
   logic [WIDTH-1:0]     dsor_q,   dsor_d;    // divisor
   logic [WIDTH:0]       rem_sh;

   assign done     = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign result   = (mode_q == ITER_MUL) ? acc_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
   assign overflow = (mode_q == ITER_MUL) && (|acc_d[2*WIDTH-1:WIDTH]);

   // Engine state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= 1'b0;
         mode_q  <= ITER_MUL;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         shreg_q <= '0;
         rem_q   <= '0;
         dsor_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         shreg_q <= shreg_d;
         rem_q   <= rem_d;
         dsor_q  <= dsor_d;
      end
   end

   // Load operands on start, then one MUL or MOD step per busy cycle
   always_comb begin
      busy_d  = busy_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      shreg_d = shreg_q;
      rem_d   = rem_q;
      dsor_d  = dsor_q;
      rem_sh  = {rem_q[WIDTH-1:0], shreg_q[WIDTH-1]};
      if (start) begin
         busy_d  = 1'b1;
         mode_d  = mode;
         cnt_d   = '0;
         acc_d   = '0;
         mcand_d = {{WIDTH{1'b0}}, a};
         shreg_d = (mode == ITER_MUL) ? b : a;
         rem_d   = '0;
         dsor_d  = b;
      end else if (busy_q) begin
         cnt_d = cnt_q + 1'b1;
         if (mode_q == ITER_MUL) begin
            if (shreg_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            shreg_d = shreg_q >> 1;
         end else begin
            rem_d   = (rem_sh >= {1'b0, dsor_q}) ? (rem_sh - {1'b0, dsor_q}) : rem_sh;
            shreg_d = shreg_q << 1;
         end
         if (done) busy_d = 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake; single-cycle ops finish on the
// accept edge, MUL and MOD are delegated to the shared shift engine.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned SLT_SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             carry,
   output logic             err
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic             zero_q,  zero_d;
   logic             carry_q, carry_d;
   logic             err_q,   err_d;

   logic             accept;
   logic             iter_start, iter_mode, iter_done, iter_ovf;
   logic [WIDTH-1:0] iter_res;
   logic [WIDTH-1:0] sc_res;
   logic             sc_carry, sc_err;
   logic [WIDTH:0]   sum, diff;
   logic             slt;

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign res       = res_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign err       = err_q;

   alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .start    (iter_start),
      .mode     (iter_mode),
      .a        (a),
      .b        (b),
      .done     (iter_done),
      .result   (iter_res),
      .overflow (iter_ovf)
   );

   // State and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end

   // Single-cycle results, including MOD-by-zero and the reserved opcode
   always_comb begin
      sum      = {1'b0, a} + {1'b0, b};
      diff     = {1'b0, a} - {1'b0, b};
      slt      = (SLT_SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_err   = 1'b0;
      case (op)
         OP_ADD: begin sc_res = sum[WIDTH-1:0];  sc_carry = sum[WIDTH];  end
         OP_SUB: begin sc_res = diff[WIDTH-1:0]; sc_carry = diff[WIDTH]; end
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, slt};
         OP_MOD: begin sc_res = a; sc_err = 1'b1; end
         default: sc_err = 1'b1;
      endcase
   end

   // Handshake FSM: accept, launch the engine or finish immediately, hold in DONE
   always_comb begin
      state_d    = state_q;
      res_d      = res_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      err_d      = err_q;
      iter_start = 1'b0;
      iter_mode  = ITER_MUL;
      if (accept) begin
         if ((op == OP_MUL) || ((op == OP_MOD) && (b != '0))) begin
            iter_start = 1'b1;
            iter_mode  = (op == OP_MOD) ? ITER_MOD : ITER_MUL;
            state_d    = ST_BUSY;
         end else begin
            res_d   = sc_res;
            zero_d  = (sc_res == '0);
            carry_d = sc_carry;
            err_d   = sc_err;
            state_d = ST_DONE;
         end
      end else begin
         case (state_q)
            ST_BUSY: begin
               if (iter_done) begin
                  res_d   = iter_res;
                  zero_d  = (iter_res == '0);
                  carry_d = iter_ovf;
                  err_d   = 1'b0;
                  state_d = ST_DONE;
               end
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = state_q;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;

   localparam int unsigned W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [2:0]    op = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_ready = 1'b1;

   logic          in_ready, out_valid, zero, carry, err;
   logic [W-1:0]  res;
   logic          in_ready_s, out_valid_s, zero_s, carry_s, err_s;
   logic [W-1:0]  res_s;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         carry;
      logic         err;
      int           lat;
   } exp_t;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W), .SLT_SIGNED(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res),
      .zero(zero), .carry(carry), .err(err)
   );

   alu_seq #(.WIDTH(W), .SLT_SIGNED(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
      .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready), .res(res_s),
      .zero(zero_s), .carry(carry_s), .err(err_s)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input bit sgn);
      exp_t e;
      longint unsigned ux, uy, p;
      ux = x; uy = y; p = 0;
      e.res = '0; e.carry = 1'b0; e.err = 1'b0; e.lat = 1;
      case (o)
         3'd0: begin p = ux + uy; e.res = p[W-1:0]; e.carry = (p > 64'd65535); end
         3'd1: begin p = ux + 64'd65536 - uy; e.res = p[W-1:0]; e.carry = (ux < uy); end
         3'd2: e.res = x & y;
         3'd3: e.res = x | y;
         3'd4: e.res = (sgn ? ($signed(x) < $signed(y)) : (ux < uy)) ? 16'd1 : 16'd0;
         3'd5: begin p = ux * uy; e.res = p[W-1:0]; e.carry = (p > 64'd65535); e.lat = W + 1; end
         3'd6: begin
            if (uy == 0) begin e.res = x; e.err = 1'b1; end
            else begin p = ux % uy; e.res = p[W-1:0]; e.lat = W + 1; end
         end
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   // Drive a request at the falling edge, return just after its accept edge
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      chk("in_ready_before_issue", in_ready, 1);
      in_valid = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int stall);
      exp_t e, es;
      int lat;
      e  = model(o, x, y, 1'b0);
      es = model(o, x, y, 1'b1);
      out_ready = (stall == 0);
      issue(o, x, y);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 2 * W + 8) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("latency op%0d", o), lat, e.lat);
      chk($sformatf("res op%0d %0h,%0h", o, x, y), res, e.res);
      chk($sformatf("carry op%0d", o), carry, e.carry);
      chk($sformatf("err op%0d", o), err, e.err);
      chk($sformatf("zero op%0d", o), zero, (e.res == '0));
      chk($sformatf("res_signed op%0d %0h,%0h", o, x, y), res_s, es.res);
      chk("out_valid_signed", out_valid_s, 1);
      chk("flags_signed", {zero_s, carry_s, err_s}, {(es.res == '0), es.carry, es.err});
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("stall_hold", {out_valid, res, zero, carry, err},
             {1'b1, e.res, (e.res == '0), e.carry, e.err});
         chk("stall_in_ready", {in_ready, in_ready_s}, 2'b00);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("consumed", out_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] ro;
      logic [W-1:0] ra, rb;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_outputs", {res, zero, carry, err}, '0);
      chk("reset_in_ready", in_ready, 1);
      @(negedge clk); rst = 1'b0;

      // Directed cases
      run_op(3'd0, 16'hFFFF, 16'h0001, 0);
      run_op(3'd1, 16'd3, 16'd5, 0);
      run_op(3'd4, 16'h8000, 16'h0001, 0);
      run_op(3'd5, 16'd300, 16'd300, 0);
      run_op(3'd5, 16'd255, 16'd255, 1);
      run_op(3'd6, 16'd1000, 16'd7, 0);
      run_op(3'd6, 16'd1234, 16'd0, 2);
      run_op(3'd7, 16'h1234, 16'h5678, 0);
      run_op(3'd2, 16'hF0F0, 16'h0FF0, 0);
      run_op(3'd3, 16'h0000, 16'h0000, 0);

      // Stall for 5 cycles, then back-to-back accept with no idle gap
      out_ready = 1'b0;
      issue(3'd0, 16'd10, 16'd20);
      chk("b2b_first_valid", out_valid, 1);
      chk("b2b_first_res", res, 16'd30);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("b2b_hold", {out_valid, res, zero, carry, err}, {1'b1, 16'd30, 3'b000});
         chk("b2b_in_ready_low", in_ready, 0);
      end
      in_valid = 1'b1; op = 3'd0; a = 16'd5; b = 16'd7;
      @(negedge clk);
      chk("b2b_still_held", res, 16'd30);
      out_ready = 1'b1;
      #1;
      chk("b2b_in_ready_comb", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_second_valid", out_valid, 1);
      chk("b2b_second_res", res, 16'd12);
      @(posedge clk); #1;
      chk("b2b_idle", out_valid, 0);

      // Asynchronous reset in the middle of a MUL
      issue(3'd5, 16'd300, 16'd300);
      repeat (8) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_outputs", {res, zero, carry, err}, '0);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      run_op(3'd5, 16'd3, 16'd4, 0);

      // Randomized operations with occasional consumer stalls
      for (int n = 0; n < 60; n++) begin
         ro = 3'($urandom_range(0, 7));
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 15));
         if (ro == 3'd6 && $urandom_range(0, 5) == 0) rb = '0;
         run_op(ro, ra, rb, $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
